// File: rtl/adq_scan_ctrl_if.sv
// Control, ADC front-end and sample-buffer write signals of the acquisition sequencer.
// master = sequencer side, slave = environment (ADC, FIFO, host control).
interface adq_scan_ctrl_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                   init;
  logic                   abort;
  logic                   cont;
  logic [N_CH-1:0]        ch_mask;
  logic                   adc_start;
  logic [CH_W-1:0]        adc_sel;
  logic                   adc_eoc;
  logic [DATA_W-1:0]      adc_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [CH_W+DATA_W-1:0] wr_data;
  logic                   busy;
  logic                   done;
  logic                   err_timeout;
  logic [2:0]             state;

  modport master (
    input  init, abort, cont, ch_mask, adc_eoc, adc_data, wr_ready,
    output adc_start, adc_sel, wr_valid, wr_data, busy, done, err_timeout, state
  );

  modport slave (
    output init, abort, cont, ch_mask, adc_eoc, adc_data, wr_ready,
    input  adc_start, adc_sel, wr_valid, wr_data, busy, done, err_timeout, state
  );
endinterface

// File: rtl/adq_scan_ctrl.sv
// Multi-channel ADC scan sequencer: walks the enabled channels, strobes conversions,
// waits for eoc with a timeout and pushes {channel,sample} downstream over valid/ready.
module adq_scan_ctrl #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned N_SWEEPS = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           rst,
  adq_scan_ctrl_if.master bus
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SW_W = (N_SWEEPS > 1) ? $clog2(N_SWEEPS) : 1;
  localparam int unsigned TM_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_CONVERT  = 3'd2,
    S_WAIT_EOC = 3'd3,
    S_STORE    = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [N_CH-1:0]        mask_q, mask_d;
  logic                   cont_q, cont_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [CH_W-1:0]        sel_q, sel_d;
  logic [SW_W-1:0]        sweep_q, sweep_d;
  logic [TM_W-1:0]        timer_q, timer_d;
  logic [CH_W+DATA_W-1:0] wdata_q, wdata_d;

  logic [CH_W-1:0]        first_in, first_q, next_ch;
  logic                   has_next;

  // Descending scan so the last hit is the lowest qualifying channel.
  always_comb begin
    first_in = '0;
    first_q  = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (bus.ch_mask[i-1]) first_in = CH_W'(i - 1);
      if (mask_q[i-1])      first_q  = CH_W'(i - 1);
      if (mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
        next_ch  = CH_W'(i - 1);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    sweep_d = sweep_q;
    timer_d = timer_q;
    wdata_d = wdata_q;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.init) begin
            mask_d  = bus.ch_mask;
            cont_d  = bus.cont;
            sweep_d = '0;
            ch_d    = first_in;
            state_d = (|bus.ch_mask) ? S_SELECT : S_DONE;
          end
        end
        S_SELECT:  state_d = S_CONVERT;
        S_CONVERT: begin
          timer_d = '0;
          state_d = S_WAIT_EOC;
        end
        S_WAIT_EOC: begin
          if (bus.adc_eoc) begin
            wdata_d = {ch_q, bus.adc_data};
            state_d = S_STORE;
          end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_STORE: begin
          if (bus.wr_ready) begin
            if (has_next) begin
              ch_d    = next_ch;
              state_d = S_SELECT;
            end else if (!cont_q && (sweep_q == SW_W'(N_SWEEPS - 1))) begin
              state_d = S_DONE;
            end else begin
              sweep_d = (sweep_q == SW_W'(N_SWEEPS - 1)) ? '0 : sweep_q + 1'b1;
              ch_d    = first_q;
              state_d = S_SELECT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Mux select is loaded on SELECT entry so it settles during the SELECT cycle.
    if (state_d == S_SELECT) sel_d = ch_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      ch_q    <= '0;
      sel_q   <= '0;
      sweep_q <= '0;
      timer_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      sweep_q <= sweep_d;
      timer_q <= timer_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.adc_start   = (state_q == S_CONVERT);
  assign bus.adc_sel     = sel_q;
  assign bus.wr_valid    = (state_q == S_STORE);
  assign bus.wr_data     = wdata_q;
  assign bus.busy        = (state_q == S_SELECT) || (state_q == S_CONVERT) ||
                           (state_q == S_WAIT_EOC) || (state_q == S_STORE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err_timeout = (state_q == S_ERROR);
  assign bus.state       = state_q;
endmodule

// File: tb/tb_adq_scan_ctrl.sv
// Randomized self-checking bench for adq_scan_ctrl; expected writes come from a
// sweep/channel list model and a queue of samples produced by the ADC responder.
module tb_adq_scan_ctrl;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned N_SWEEPS = 2;
  localparam int unsigned TIMEOUT  = 12;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  adq_scan_ctrl_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  adq_scan_ctrl #(
    .N_CH(N_CH), .DATA_W(DATA_W), .N_SWEEPS(N_SWEEPS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC responder: eoc pulse a random number of cycles after each start strobe.
  logic              auto_eoc, man_eoc;
  logic [DATA_W-1:0] auto_data, man_data;
  bit                adc_en;
  int                adc_cnt;
  int unsigned       dly_lo, dly_hi;
  logic [DATA_W-1:0] adc_q[$];

  assign bus.adc_eoc  = auto_eoc | man_eoc;
  assign bus.adc_data = man_eoc ? man_data : auto_data;

  initial begin
    auto_eoc  = 1'b0;
    auto_data = '0;
    adc_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      auto_eoc = 1'b0;
      if (!adc_en || rst) begin
        adc_cnt = 0;
      end else if (bus.adc_start) begin
        adc_cnt = int'($urandom_range(dly_hi, dly_lo));
      end else if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin
          auto_eoc  = 1'b1;
          auto_data = DATA_W'($urandom);
          adc_q.push_back(auto_data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input logic [N_CH-1:0] m, input logic c);
    bus.ch_mask = m;
    bus.cont    = c;
    bus.init    = 1'b1;
    cyc();
    bus.init    = 1'b0;
    bus.ch_mask = N_CH'($urandom);
    bus.cont    = 1'($urandom);
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    int n;
    n = 0;
    while (bus.state !== s && n < 200) begin
      cyc();
      n++;
    end
    ok = (bus.state === s);
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (bus.wr_valid !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    ok = (bus.wr_valid === 1'b1);
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    rst = 1'b1;
    cyc();
    cyc();
    outs = {bus.adc_start, bus.adc_sel, bus.wr_valid, bus.wr_data,
            bus.busy, bus.done, bus.err_timeout, bus.state};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    #2 rst = 1'b0;
    cyc();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle state got=%0d exp=0", bus.state);
    end
  endtask

  task automatic test_single_sweeps();
    logic [N_CH-1:0]   m;
    int                exp_ch[$];
    int                got, budget, total;
    bit                rand_rdy, rdy;
    logic [DATA_W-1:0] exp_d;
    for (int it = 0; it < 6; it++) begin
      m        = (it == 0) ? 4'b0101 : N_CH'($urandom_range(15, 1));
      rand_rdy = (it != 0);
      dly_lo   = (it == 0) ? 3 : 1;
      dly_hi   = (it == 0) ? 3 : 4;
      exp_ch.delete();
      for (int s = 0; s < int'(N_SWEEPS); s++)
        for (int c = 0; c < int'(N_CH); c++)
          if (m[c]) exp_ch.push_back(c);
      total  = exp_ch.size();
      adc_q.delete();
      adc_en = 1'b1;
      pulse_init(m, 1'b0);
      got    = 0;
      budget = 0;
      while (got < total && budget < 500) begin
        rdy = rand_rdy ? ($urandom_range(3, 0) != 0) : 1'b1;
        bus.wr_ready = rdy;
        if (bus.wr_valid === 1'b1 && rdy) begin
          checks++;
          if (bus.wr_data[CH_W+DATA_W-1:DATA_W] !== CH_W'(exp_ch[got])) begin
            errors++;
            $display("FAIL single_ch it=%0d w=%0d got=%0d exp=%0d", it, got,
                     bus.wr_data[CH_W+DATA_W-1:DATA_W], exp_ch[got]);
          end
          exp_d = 'x;
          if (adc_q.size() > 0) exp_d = adc_q.pop_front();
          checks++;
          if (bus.wr_data[DATA_W-1:0] !== exp_d) begin
            errors++;
            $display("FAIL single_data it=%0d w=%0d got=%h exp=%h", it, got,
                     bus.wr_data[DATA_W-1:0], exp_d);
          end
          got++;
        end
        cyc();
        budget++;
      end
      checks++;
      if (got != total) begin
        errors++;
        $display("FAIL single_count it=%0d got=%0d exp=%0d", it, got, total);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.state !== 3'd5 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL single_done it=%0d done=%b state=%0d busy=%b exp done=1 state=5 busy=0",
                 it, bus.done, bus.state, bus.busy);
      end
    end
  endtask

  task automatic test_backpressure();
    bit                ok;
    logic [CH_W+DATA_W-1:0] held, exp_w;
    bit                bad;
    adc_en = 1'b1;
    dly_lo = 2;
    dly_hi = 2;
    adc_q.delete();
    bus.wr_ready = 1'b0;
    pulse_init(4'b0110, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid_timeout got=0 exp=1");
    end
    held  = bus.wr_data;
    exp_w = 'x;
    if (adc_q.size() > 0) exp_w = {CH_W'(1), adc_q[0]};
    checks++;
    if (held !== exp_w) begin
      errors++;
      $display("FAIL bp_data got=%h exp=%h", held, exp_w);
    end
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (bus.wr_valid !== 1'b1 || bus.wr_data !== held ||
          bus.adc_start !== 1'b0 || bus.state !== 3'd4) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold valid=%b data=%h start=%b exp valid=1 data=%h start=0",
               bus.wr_valid, bus.wr_data, bus.adc_start, held);
    end
    bus.wr_ready = 1'b1;
    cyc();
    checks++;
    if (bus.wr_valid !== 1'b0 || bus.state !== 3'd1 || bus.adc_sel !== CH_W'(2)) begin
      errors++;
      $display("FAIL bp_release valid=%b state=%0d sel=%0d exp valid=0 state=1 sel=2",
               bus.wr_valid, bus.state, bus.adc_sel);
    end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok, bad;
    adc_en = 1'b0;
    bus.wr_ready = 1'b1;
    pulse_init(4'b0100, 1'b0);
    wait_state(3'd3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_wait_entry state=%0d exp=3", bus.state);
    end
    bad = 1'b0;
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      cyc();
      if (bus.state !== 3'd3) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL to_early_exit state=%0d exp=3", bus.state);
    end
    cyc();
    checks++;
    if (bus.state !== 3'd6 || bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_error state=%0d err=%b busy=%b exp state=6 err=1 busy=0",
               bus.state, bus.err_timeout, bus.busy);
    end
    repeat (3) cyc();
    checks++;
    if (bus.err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_hold err=%b exp=1", bus.err_timeout);
    end
    pulse_init(4'b0001, 1'b0);
    checks++;
    if (bus.state !== 3'd1 || bus.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_restart state=%0d err=%b exp state=1 err=0", bus.state, bus.err_timeout);
    end
    wait_state(3'd3, ok);
    repeat (TIMEOUT - 1) cyc();
    man_data = DATA_W'($urandom);
    man_eoc  = 1'b1;
    cyc();
    man_eoc  = 1'b0;
    checks++;
    if (bus.state !== 3'd4 || bus.wr_data !== {CH_W'(0), man_data}) begin
      errors++;
      $display("FAIL to_eoc_wins state=%0d data=%h exp state=4 data=%h",
               bus.state, bus.wr_data, {CH_W'(0), man_data});
    end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  task automatic test_continuous();
    bit                ok, rdy, saw_done;
    int                got, budget;
    logic [DATA_W-1:0] exp_d;
    adc_en = 1'b1;
    dly_lo = 1;
    dly_hi = 3;
    adc_q.delete();
    pulse_init(4'b1000, 1'b1);
    got      = 0;
    budget   = 0;
    saw_done = 1'b0;
    while (got < int'(N_SWEEPS) + 3 && budget < 300) begin
      rdy = ($urandom_range(3, 0) != 0);
      bus.wr_ready = rdy;
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.wr_valid === 1'b1 && rdy) begin
        exp_d = 'x;
        if (adc_q.size() > 0) exp_d = adc_q.pop_front();
        checks++;
        if (bus.wr_data !== {CH_W'(3), exp_d}) begin
          errors++;
          $display("FAIL cont_write w=%0d got=%h exp=%h", got, bus.wr_data, {CH_W'(3), exp_d});
        end
        got++;
      end
      cyc();
      budget++;
    end
    checks++;
    if (got != int'(N_SWEEPS) + 3 || saw_done) begin
      errors++;
      $display("FAIL cont_run writes=%0d done_seen=%b exp writes=%0d done_seen=0",
               got, saw_done, N_SWEEPS + 3);
    end
    bus.wr_ready = 1'b0;
    wait_valid(ok);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    checks++;
    if (!ok || bus.state !== 3'd0 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_abort ok=%b state=%0d valid=%b busy=%b exp state=0 valid=0 busy=0",
               ok, bus.state, bus.wr_valid, bus.busy);
    end
  endtask

  task automatic test_mask_zero();
    int                got, budget;
    logic [DATA_W-1:0] exp_d;
    adc_en = 1'b1;
    dly_lo = 1;
    dly_hi = 2;
    pulse_init(4'b0000, 1'b0);
    checks++;
    if (bus.state !== 3'd5 || bus.done !== 1'b1 || bus.adc_start !== 1'b0) begin
      errors++;
      $display("FAIL mz_done state=%0d done=%b start=%b exp state=5 done=1 start=0",
               bus.state, bus.done, bus.adc_start);
    end
    adc_q.delete();
    bus.wr_ready = 1'b1;
    pulse_init(4'b0001, 1'b0);
    cyc();
    bus.ch_mask = 4'b1110;
    bus.cont    = 1'b1;
    bus.init    = 1'b1;
    cyc();
    bus.init    = 1'b0;
    checks++;
    if (bus.state !== 3'd3) begin
      errors++;
      $display("FAIL mz_busy_init state=%0d exp=3", bus.state);
    end
    got    = 0;
    budget = 0;
    while (got < int'(N_SWEEPS) && budget < 100) begin
      if (bus.wr_valid === 1'b1) begin
        exp_d = 'x;
        if (adc_q.size() > 0) exp_d = adc_q.pop_front();
        checks++;
        if (bus.wr_data !== {CH_W'(0), exp_d}) begin
          errors++;
          $display("FAIL mz_write w=%0d got=%h exp=%h", got, bus.wr_data, {CH_W'(0), exp_d});
        end
        got++;
      end
      cyc();
      budget++;
    end
    checks++;
    if (got != int'(N_SWEEPS) || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL mz_finish writes=%0d done=%b exp writes=%0d done=1", got, bus.done, N_SWEEPS);
    end
  endtask

  task automatic test_async_reset();
    bit          ok;
    logic [23:0] outs;
    adc_en = 1'b0;
    pulse_init(4'b0100, 1'b0);
    wait_state(3'd3, ok);
    cyc();
    #2 rst = 1'b1;
    #1;
    outs = {bus.adc_start, bus.adc_sel, bus.wr_valid, bus.wr_data,
            bus.busy, bus.done, bus.err_timeout, bus.state};
    checks++;
    if (!ok || outs !== '0) begin
      errors++;
      $display("FAIL async_reset ok=%b outs=%h exp=0", ok, outs);
    end
    cyc();
    #3 rst = 1'b0;
    cyc();
    adc_en = 1'b1;
    pulse_init(4'b0010, 1'b0);
    checks++;
    if (bus.state !== 3'd1 || bus.adc_sel !== CH_W'(1)) begin
      errors++;
      $display("FAIL async_recover state=%0d sel=%0d exp state=1 sel=1", bus.state, bus.adc_sel);
    end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    adc_en       = 1'b0;
    dly_lo       = 1;
    dly_hi       = 4;
    man_eoc      = 1'b0;
    man_data     = '0;
    bus.init     = 1'b0;
    bus.abort    = 1'b0;
    bus.cont     = 1'b0;
    bus.ch_mask  = '0;
    bus.wr_ready = 1'b0;
    test_reset();
    test_single_sweeps();
    test_backpressure();
    test_timeout();
    test_continuous();
    test_mask_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
